seq_mult_core: RTL and testbench

//  Parametrised iterative multiplier: WIDTH x WIDTH -> 2*WIDTH, built from one DIGIT x DIGIT

---
 rtl/seq_mult_pkg.sv | 20 ++
 rtl/seq_mult_digit_mult.sv | 13 +
 rtl/seq_mult_core.sv | 117 +++++++++++
 tb/tb_seq_mult_core.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_mult_pkg.sv
// Shared definitions for the iterative digit multiplier: FSM state encoding
// and the step-counter width function also used by unit-level scoreboards.
package seq_mult_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_CALC   = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

    // Bits needed to count n steps (clog2), never less than one.
    function automatic int count_width(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) w++;
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/seq_mult_digit_mult.sv
// Combinational DIGIT x DIGIT -> 2*DIGIT unsigned multiplier, reused every
// CALC cycle by seq_mult_core.
module digit_mult #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0]   x,
    input  logic [DIGIT-1:0]   y,
    output logic [2*DIGIT-1:0] p
);

    assign p = (2*DIGIT)'(x) * (2*DIGIT)'(y);

endmodule

// File: rtl/seq_mult_core.sv
// Iterative WIDTH x WIDTH multiplier: one digit product per cycle, shift-accumulated.
// Optional two's-complement mode enabled by defining SEQ_MULT_SIGNED_EN.
module seq_mult_core
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
`ifdef SEQ_MULT_SIGNED_EN
    input  logic               signed_op,
`endif
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int NDIG  = WIDTH / DIGIT;
    localparam int NSTEP = NDIG * NDIG;
    localparam int CW    = count_width(NSTEP);

    generate
        if ((DIGIT < 1) || (WIDTH % DIGIT != 0)) begin : g_bad_param
            $error("seq_mult_core: WIDTH must be a positive multiple of DIGIT");
        end
    endgenerate

    state_t             state;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      count;
    logic [CW-1:0]      idx_i;
    logic [CW-1:0]      idx_j;
    logic [DIGIT-1:0]   dig_a;
    logic [DIGIT-1:0]   dig_b;
    logic [2*DIGIT-1:0] dig_p;
    logic [2*WIDTH-1:0] pp;
    logic [2*WIDTH-1:0] sum;
    logic [2*WIDTH-1:0] result;

    // count walks the digit grid with the multiplicand digit varying fastest.
    assign idx_i = CW'(int'(count) % NDIG);
    assign idx_j = CW'(int'(count) / NDIG);
    assign dig_a = op_a[int'(idx_i)*DIGIT +: DIGIT];
    assign dig_b = op_b[int'(idx_j)*DIGIT +: DIGIT];

    digit_mult #(.DIGIT(DIGIT)) u_digit (
        .x (dig_a),
        .y (dig_b),
        .p (dig_p)
    );

    assign pp  = (2*WIDTH)'(dig_p) << (DIGIT * (int'(idx_i) + int'(idx_j)));
    assign sum = acc + pp;

`ifdef SEQ_MULT_SIGNED_EN
    logic neg;
    assign result = neg ? -sum : sum;
`else
    assign result = sum;
`endif

    assign busy = (state == ST_LOAD) || (state == ST_CALC);
    assign done = (state == ST_FINISH);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            op_a    <= '0;
            op_b    <= '0;
            acc     <= '0;
            count   <= '0;
            product <= '0;
`ifdef SEQ_MULT_SIGNED_EN
            neg     <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
`ifdef SEQ_MULT_SIGNED_EN
                        // Datapath is unsigned: keep magnitudes, fix the sign at the end.
                        op_a  <= (signed_op && a[WIDTH-1]) ? -a : a;
                        op_b  <= (signed_op && b[WIDTH-1]) ? -b : b;
                        neg   <= signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
`else
                        op_a  <= a;
                        op_b  <= b;
`endif
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    acc   <= '0;
                    count <= '0;
                    state <= ST_CALC;
                end
                ST_CALC: begin
                    acc   <= sum;
                    count <= count + 1'b1;
                    if (count == CW'(NSTEP - 1)) begin
                        product <= result;
                        state   <= ST_FINISH;
                    end
                end
                ST_FINISH: state <= ST_IDLE;
                default:   state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mult_core.sv
// Directed bench for seq_mult_core: 8/4, 16/4 and 8/8 instances share clock and reset.
// Signed-mode vectors are included when SEQ_MULT_SIGNED_EN is defined.
module tb_seq_mult_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        s8, s16, s88;
    logic [7:0]  a8, b8, a88, b88;
    logic [15:0] a16, b16;
    logic        busy8, done8, busy16, done16, busy88, done88;
    logic [15:0] p8, p88;
    logic [31:0] p16;
`ifdef SEQ_MULT_SIGNED_EN
    logic        sg8, sg16, sg88;
`endif

    int checks = 0;
    int errors = 0;

    seq_mult_core #(.WIDTH(8), .DIGIT(4)) u8 (
        .clk(clk), .rst(rst), .start(s8),
`ifdef SEQ_MULT_SIGNED_EN
        .signed_op(sg8),
`endif
        .a(a8), .b(b8), .busy(busy8), .done(done8), .product(p8)
    );

    seq_mult_core #(.WIDTH(16), .DIGIT(4)) u16 (
        .clk(clk), .rst(rst), .start(s16),
`ifdef SEQ_MULT_SIGNED_EN
        .signed_op(sg16),
`endif
        .a(a16), .b(b16), .busy(busy16), .done(done16), .product(p16)
    );

    seq_mult_core #(.WIDTH(8), .DIGIT(8)) u88 (
        .clk(clk), .rst(rst), .start(s88),
`ifdef SEQ_MULT_SIGNED_EN
        .signed_op(sg88),
`endif
        .a(a88), .b(b88), .busy(busy88), .done(done88), .product(p88)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start on the 8/4 instance, then watch 20 cycles for done.
    task automatic run_op8(input logic [7:0] x, input logic [7:0] y,
                           output int done_at, output int done_cnt);
        a8 = x; b8 = y; s8 = 1'b1;
        done_at = -1; done_cnt = 0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            s8 = 1'b0;
            if (done8) begin
                done_cnt++;
                if (done_at < 0) done_at = c;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        s8 = 1'b1; s16 = 1'b1; s88 = 1'b1;
        a8 = 8'h11; b8 = 8'h22; a16 = 16'h1111; b16 = 16'h2222; a88 = 8'h33; b88 = 8'h44;
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++;
            if (busy8 !== 1'b0 || done8 !== 1'b0 || p8 !== 16'h0) begin
                errors++;
                $display("FAIL reset_8x4 cycle %0d: busy=%b done=%b product=%h, want 0/0/0000", c, busy8, done8, p8);
            end
            checks++;
            if (busy16 !== 1'b0 || done16 !== 1'b0 || p16 !== 32'h0) begin
                errors++;
                $display("FAIL reset_16x4 cycle %0d: busy=%b done=%b product=%h, want 0/0/0", c, busy16, done16, p16);
            end
            checks++;
            if (busy88 !== 1'b0 || done88 !== 1'b0 || p88 !== 16'h0) begin
                errors++;
                $display("FAIL reset_8x8 cycle %0d: busy=%b done=%b product=%h, want 0/0/0000", c, busy88, done88, p88);
            end
        end
        rst = 1'b0; s8 = 1'b0; s16 = 1'b0; s88 = 1'b0;
        tick();
        checks++;
        if (busy8 !== 1'b0 || busy16 !== 1'b0 || busy88 !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_accept: busy=%b%b%b, want 000", busy8, busy16, busy88);
        end
    endtask

    task automatic test_full_scale();
        logic exp_busy, exp_done;
        a8 = 8'hFF; b8 = 8'hFF; s8 = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            tick();
            s8 = 1'b0;
            exp_busy = (c >= 1 && c <= 5);
            exp_done = (c == 6);
            checks++;
            if (busy8 !== exp_busy || done8 !== exp_done) begin
                errors++;
                $display("FAIL full_scale_timing t+%0d: busy=%b done=%b, want %b/%b", c, busy8, done8, exp_busy, exp_done);
            end
            if (c >= 6) begin
                checks++;
                if (p8 !== 16'hFE01) begin
                    errors++;
                    $display("FAIL full_scale_product t+%0d: got %h, want fe01", c, p8);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic exp_busy, exp_done;
        a8 = 8'd3; b8 = 8'd5; s8 = 1'b1;
        for (int c = 1; c <= 13; c++) begin
            tick();
            if (c == 2) a8 = 8'd9;
            exp_busy = (c >= 1 && c <= 5) || (c >= 8 && c <= 12);
            exp_done = (c == 6) || (c == 13);
            checks++;
            if (busy8 !== exp_busy || done8 !== exp_done) begin
                errors++;
                $display("FAIL back_to_back_timing t+%0d: busy=%b done=%b, want %b/%b", c, busy8, done8, exp_busy, exp_done);
            end
            if (c == 6) begin
                checks++;
                if (p8 !== 16'h000F) begin
                    errors++;
                    $display("FAIL back_to_back_first: got %h, want 000f", p8);
                end
            end
            if (c == 13) begin
                checks++;
                if (p8 !== 16'h002D) begin
                    errors++;
                    $display("FAIL back_to_back_second: got %h, want 002d", p8);
                end
            end
        end
        s8 = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        int done_at, done_cnt;
        int stray;
        a8 = 8'h12; b8 = 8'h34; s8 = 1'b1;
        tick();          // t+1 LOAD
        s8 = 1'b0;
        tick();          // t+2 first CALC
        tick();          // t+3 second CALC
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (busy8 !== 1'b0 || done8 !== 1'b0 || p8 !== 16'h0) begin
            errors++;
            $display("FAIL reset_mid_op: busy=%b done=%b product=%h, want 0/0/0000", busy8, done8, p8);
        end
        stray = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (done8 || busy8) stray++;
        end
        checks++;
        if (stray !== 0) begin
            errors++;
            $display("FAIL reset_mid_quiet: %0d busy/done cycles after abort, want 0", stray);
        end
        run_op8(8'd2, 8'd7, done_at, done_cnt);
        checks++;
        if (p8 !== 16'h000E || done_at !== 6 || done_cnt !== 1) begin
            errors++;
            $display("FAIL reset_mid_next_op: product=%h done_at=%0d pulses=%0d, want 000e/6/1", p8, done_at, done_cnt);
        end
    endtask

    task automatic test_vectors();
        logic [7:0]  va [4] = '{8'h12, 8'h00, 8'h80, 8'hFF};
        logic [7:0]  vb [4] = '{8'h34, 8'h5A, 8'h80, 8'h03};
        logic [15:0] vp [4] = '{16'h03A8, 16'h0000, 16'h4000, 16'h02FD};
        int done_at, done_cnt;
        for (int k = 0; k < 4; k++) begin
            run_op8(va[k], vb[k], done_at, done_cnt);
            checks++;
            if (p8 !== vp[k] || done_at !== 6 || done_cnt !== 1) begin
                errors++;
                $display("FAIL vector_%0d %h*%h: product=%h done_at=%0d pulses=%0d, want %h/6/1",
                         k, va[k], vb[k], p8, done_at, done_cnt, vp[k]);
            end
        end
    endtask

    task automatic test_wide_and_one_step();
        int done_at;
        a16 = 16'hABCD; b16 = 16'h1234; s16 = 1'b1;
        done_at = -1;
        for (int c = 1; c <= 25; c++) begin
            tick();
            s16 = 1'b0;
            if (done16 && done_at < 0) done_at = c;
        end
        checks++;
        if (p16 !== 32'h0C374FA4 || done_at !== 18) begin
            errors++;
            $display("FAIL wide_16x4: product=%h done_at=%0d, want 0c374fa4/18", p16, done_at);
        end
        a88 = 8'hFF; b88 = 8'h02; s88 = 1'b1;
        done_at = -1;
        for (int c = 1; c <= 8; c++) begin
            tick();
            s88 = 1'b0;
            if (done88 && done_at < 0) done_at = c;
        end
        checks++;
        if (p88 !== 16'h01FE || done_at !== 3) begin
            errors++;
            $display("FAIL one_step_8x8: product=%h done_at=%0d, want 01fe/3", p88, done_at);
        end
    endtask

`ifdef SEQ_MULT_SIGNED_EN
    task automatic test_signed();
        int done_at, done_cnt;
        sg8 = 1'b1;
        run_op8(8'h80, 8'h80, done_at, done_cnt);
        checks++;
        if (p8 !== 16'h4000 || done_at !== 6) begin
            errors++;
            $display("FAIL signed_80x80: product=%h done_at=%0d, want 4000/6", p8, done_at);
        end
        run_op8(8'hFF, 8'h03, done_at, done_cnt);
        checks++;
        if (p8 !== 16'hFFFD || done_at !== 6) begin
            errors++;
            $display("FAIL signed_ffx03: product=%h done_at=%0d, want fffd/6", p8, done_at);
        end
        sg8 = 1'b0;
        run_op8(8'hFF, 8'h03, done_at, done_cnt);
        checks++;
        if (p8 !== 16'h02FD || done_at !== 6) begin
            errors++;
            $display("FAIL unsigned_ffx03: product=%h done_at=%0d, want 02fd/6", p8, done_at);
        end
    endtask
`endif

    initial begin
        rst = 1'b1;
        s8 = 1'b0; s16 = 1'b0; s88 = 1'b0;
        a8 = '0; b8 = '0; a16 = '0; b16 = '0; a88 = '0; b88 = '0;
`ifdef SEQ_MULT_SIGNED_EN
        sg8 = 1'b0; sg16 = 1'b0; sg88 = 1'b0;
`endif
        test_reset();
        test_full_scale();
        test_back_to_back();
        test_reset_mid();
        test_vectors();
        test_wide_and_one_step();
`ifdef SEQ_MULT_SIGNED_EN
        test_signed();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
